// File: rtl/bkg_calib_ctrl.sv
// Background calibration sequencer: averages 2^LOG2_FRAMES snooped frames per
// channel and writes the per-word averages into the background memory.
module bkg_calib_ctrl #(
  parameter int FRAME_WORDS = 163,
  parameter int HDR_WORDS   = 3,
  parameter int LOG2_FRAMES = 4
) (
  input  logic        clk_clk,
  input  logic        int_rst,
  input  logic        cal_start,
  input  logic        cal_abort,
  output logic        cal_busy,
  output logic        cal_done,
  output logic        cal_error,
  input  logic [31:0] st_data,
  input  logic        st_valid,
  input  logic        st_ready,
  input  logic        st_sop,
  input  logic        st_eop,
  output logic        bkg_wr_en,
  output logic [8:0]  bkg_wr_addr,
  output logic [31:0] bkg_wr_data
);

  localparam int DATA_WORDS = FRAME_WORDS - HDR_WORDS;
  localparam int ACC_W      = 16 + LOG2_FRAMES;
  localparam int BW         = $clog2(FRAME_WORDS + 1);
  localparam int AW         = $clog2(DATA_WORDS);

  localparam logic [BW-1:0] HDR_B   = BW'(HDR_WORDS);
  localparam logic [BW-1:0] LAST_B  = BW'(FRAME_WORDS - 1);
  localparam logic [AW-1:0] LAST_RD = AW'(DATA_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE, WAIT_SOP, ACCUM, WRITE, DONE, ERROR
  } state_t;

  state_t                 state, state_nxt;
  logic [BW-1:0]          beat_ctr, beat_nxt;
  logic [LOG2_FRAMES-1:0] frame_ctr, frame_nxt;
  logic [AW-1:0]          rd_ctr, rd_nxt;
  logic                   busy_nxt, done_nxt, error_nxt, wr_en_nxt;
  logic                   acc_we;

  logic [ACC_W-1:0] acc_hi [DATA_WORDS];
  logic [ACC_W-1:0] acc_lo [DATA_WORDS];

  logic          beat;
  logic [AW-1:0] acc_idx;
  logic [15:0]   rd_hi, rd_lo;

  assign beat    = st_valid & st_ready;
  assign acc_idx = AW'(beat_ctr - HDR_B);
  assign rd_hi   = 16'(acc_hi[rd_ctr] >> LOG2_FRAMES);
  assign rd_lo   = 16'(acc_lo[rd_ctr] >> LOG2_FRAMES);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
    state_nxt = state;
    beat_nxt  = beat_ctr;
    frame_nxt = frame_ctr;
    rd_nxt    = rd_ctr;
    acc_we    = 1'b0;
    case (state)
      IDLE: begin
        frame_nxt = '0;
        if (cal_start && !cal_abort) state_nxt = WAIT_SOP;
      end
      WAIT_SOP: begin
        if (beat && st_sop) begin
          state_nxt = ACCUM;
          beat_nxt  = BW'(1);
        end
      end
      ACCUM: begin
        if (beat) begin
          beat_nxt = beat_ctr + 1'b1;
          if (st_sop) begin
            state_nxt = ERROR;
          end else begin
            acc_we = (beat_ctr >= HDR_B);
            if (beat_ctr == LAST_B) begin
              if (st_eop) begin
                frame_nxt = frame_ctr + 1'b1;
                rd_nxt    = '0;
                state_nxt = (&frame_ctr) ? WRITE : WAIT_SOP;
              end else begin
                state_nxt = ERROR;
              end
            end else if (st_eop) begin
              state_nxt = ERROR;
            end
          end
        end
      end
      WRITE: begin
        rd_nxt = rd_ctr + 1'b1;
        if (rd_ctr == LAST_RD) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      ERROR:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Abort wins over every other transition and suppresses done/error pulses.
    if (cal_abort && state != IDLE) state_nxt = IDLE;

    busy_nxt  = (state_nxt != IDLE);
    done_nxt  = (state == DONE)  && !cal_abort;
    error_nxt = (state == ERROR) && !cal_abort;
    wr_en_nxt = (state == WRITE) && !cal_abort;
  end

  always_ff @(posedge clk_clk or posedge int_rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (int_rst) begin
      state       <= IDLE;
      beat_ctr    <= '0;
      frame_ctr   <= '0;
      rd_ctr      <= '0;
      cal_busy    <= 1'b0;
      cal_done    <= 1'b0;
      cal_error   <= 1'b0;
      bkg_wr_en   <= 1'b0;
      bkg_wr_addr <= '0;
      bkg_wr_data <= '0;
    end else begin
      state     <= state_nxt;
      beat_ctr  <= beat_nxt;
      frame_ctr <= frame_nxt;
      rd_ctr    <= rd_nxt;
      cal_busy  <= busy_nxt;
      cal_done  <= done_nxt;
      cal_error <= error_nxt;
      bkg_wr_en <= wr_en_nxt;
      if (wr_en_nxt) begin
        bkg_wr_addr <= 9'(rd_ctr);
        bkg_wr_data <= {rd_hi, rd_lo};
      end
    end
  end

  // Frame 0 overwrites each entry, so stale contents never need clearing.
  always_ff @(posedge clk_clk) begin
    // NOTE: the accumulator has no reset so it can map onto RAM; frame 0 loads it before any read.
    if (acc_we) begin
      acc_hi[acc_idx] <= (frame_ctr == '0) ? ACC_W'(st_data[31:16])
                                           : acc_hi[acc_idx] + ACC_W'(st_data[31:16]);
      acc_lo[acc_idx] <= (frame_ctr == '0) ? ACC_W'(st_data[15:0])
                                           : acc_lo[acc_idx] + ACC_W'(st_data[15:0]);
    end
  end

endmodule

// File: tb/tb_bkg_calib_ctrl.sv
// Bench for bkg_calib_ctrl with 4-frame averaging: directed scenarios with
// random frame contents, checked against a per-word average model.
module tb_bkg_calib_ctrl;

  localparam int FW = 163;
  localparam int HW = 3;
  localparam int DW = FW - HW;
  localparam int L2 = 2;
  localparam int NF = 1 << L2;

  logic        clk_clk = 1'b0;
  logic        int_rst;
  logic        cal_start, cal_abort;
  logic        cal_busy, cal_done, cal_error;
  logic [31:0] st_data;
  logic        st_valid, st_ready, st_sop, st_eop;
  logic        bkg_wr_en;
  logic [8:0]  bkg_wr_addr;
  logic [31:0] bkg_wr_data;

  bkg_calib_ctrl #(.FRAME_WORDS(FW), .HDR_WORDS(HW), .LOG2_FRAMES(L2)) dut (
    .clk_clk(clk_clk), .int_rst(int_rst),
    .cal_start(cal_start), .cal_abort(cal_abort),
    .cal_busy(cal_busy), .cal_done(cal_done), .cal_error(cal_error),
    .st_data(st_data), .st_valid(st_valid), .st_ready(st_ready),
    .st_sop(st_sop), .st_eop(st_eop),
    .bkg_wr_en(bkg_wr_en), .bkg_wr_addr(bkg_wr_addr), .bkg_wr_data(bkg_wr_data)
  );

  always #5 clk_clk = ~clk_clk;

  int total = 0;
  int bad   = 0;

  // Slots 0..3 are the frames that should be averaged; slot 4 is for skipped or broken frames.
  logic [31:0] fd [5][DW];

  // Monitor state (written only by the monitor process).
  logic [31:0] got [DW];
  int   cyc = 0, wr_cnt = 0, done_cnt = 0, err_cnt = 0, addr_bad = 0;
  int   last_wr_cyc = 0, done_cyc = 0;
  logic done_busy = 1'b0, err_busy = 1'b0, prev_en = 1'b0;
  logic [8:0] prev_addr = '0;
  logic abort_busy;

  always @(negedge clk_clk) begin
    cyc++;
    if (bkg_wr_en) begin
      if (bkg_wr_addr != (prev_en ? prev_addr + 9'd1 : 9'd0)) addr_bad++;
      if (bkg_wr_addr < 9'(DW)) got[bkg_wr_addr] = bkg_wr_data;
      wr_cnt++;
      last_wr_cyc = cyc;
    end
    prev_en   = bkg_wr_en;
    prev_addr = bkg_wr_addr;
    if (cal_done)  begin done_cnt++; done_cyc = cyc; done_busy = cal_busy; end
    if (cal_error) begin err_cnt++;  err_busy = cal_busy; end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain per-channel sum over the four frames, then truncating divide.
  function automatic logic [31:0] model(input int w);
    int hi = 0, lo = 0;
    for (int f = 0; f < NF; f++) begin
      hi += int'(fd[f][w][31:16]);
      lo += int'(fd[f][w][15:0]);
    end
    return {16'(hi / NF), 16'(lo / NF)};
  endfunction

  task automatic fill(input int mode);
    for (int f = 0; f < 5; f++)
      for (int w = 0; w < DW; w++) begin
        if (mode == 0 && f < NF) fd[f][w] = 32'h0010_0020;
        else                     fd[f][w] = $urandom;
        if (mode == 1 && f < NF && w == 5) fd[f][w] = {16'(f + 1), 16'hFFFF};
      end
  endtask

  // One frame of nb beats; sop on beat 0, eop on beat nb-1; optional start/abort on a beat.
  task automatic send_frame(input int slot, input int nb, input int start_at,
                            input int abort_at, input bit bp);
    for (int i = 0; i < nb; i++) begin
      while (bp && $urandom_range(0, 2) == 0) begin
        cal_start = 1'b0; cal_abort = 1'b0;
        st_valid = 1'b1; st_ready = 1'b0; st_data = $urandom;
        st_sop = 1'($urandom); st_eop = 1'($urandom);
        @(posedge clk_clk); #1;
      end
      cal_start = (i == start_at);
      cal_abort = (i == abort_at);
      st_valid  = 1'b1;
      st_ready  = 1'b1;
      st_sop    = (i == 0);
      st_eop    = (i == nb - 1);
      st_data   = (i < HW) ? 32'hDEAD_BEEF : ((i - HW < DW) ? fd[slot][i - HW] : $urandom);
      @(posedge clk_clk); #1;
      if (i == abort_at) abort_busy = cal_busy;
    end
    st_valid = 1'b0; st_sop = 1'b0; st_eop = 1'b0;
    cal_start = 1'b0; cal_abort = 1'b0;
  endtask

  task automatic pulse_start();
    cal_start = 1'b1;
    @(posedge clk_clk); #1;
    cal_start = 1'b0;
    check("busy_after_start", cal_busy, 1'b1);
  endtask

  // Full calibration: start, four good frames, then verify writes, done timing and averages.
  task automatic run_full(input string tag, input bit bp, input bit mid_start);
    int w0, d0, e0, n, mism;
    w0 = wr_cnt; d0 = done_cnt; e0 = err_cnt;
    if (mid_start) send_frame(4, FW, 80, -1, 1'b0);
    else           pulse_start();
    for (int f = 0; f < NF; f++) send_frame(f, FW, -1, -1, bp);
    n = 0;
    while (done_cnt == d0 && n < 400) begin @(posedge clk_clk); #1; n++; end
    repeat (3) @(posedge clk_clk);
    #1;
    check({tag, "_done_seen"}, 32'(done_cnt != d0), 32'd1);
    check({tag, "_wr_count"},  32'(wr_cnt - w0),    32'(DW));
    check({tag, "_done_count"}, 32'(done_cnt - d0), 32'd1);
    check({tag, "_done_lat"},  32'(done_cyc),       32'(last_wr_cyc + 1));
    check({tag, "_busy_at_done"}, done_busy, 1'b0);
    check({tag, "_no_error"},  32'(err_cnt - e0),   32'd0);
    check({tag, "_addr_seq"},  32'(addr_bad),       32'd0);
    mism = 0;
    for (int w = 0; w < DW; w++) if (got[w] !== model(w)) mism++;
    check({tag, "_avg_mismatch_words"}, 32'(mism), 32'd0);
    check({tag, "_avg_w0"},   got[0],      model(0));
    check({tag, "_avg_w159"}, got[DW - 1], model(DW - 1));
  endtask

  task automatic run_bad(input string tag, input int nb);
    int w0, d0, e0;
    w0 = wr_cnt; d0 = done_cnt; e0 = err_cnt;
    pulse_start();
    send_frame(0, FW, -1, -1, 1'b0);
    send_frame(4, nb, -1, -1, 1'b0);
    repeat (6) @(posedge clk_clk);
    #1;
    check({tag, "_err_count"},   32'(err_cnt - e0),  32'd1);
    check({tag, "_busy_at_err"}, err_busy,           1'b0);
    check({tag, "_no_writes"},   32'(wr_cnt - w0),   32'd0);
    check({tag, "_no_done"},     32'(done_cnt - d0), 32'd0);
    check({tag, "_idle_busy"},   cal_busy,           1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w0, d0, e0, n;
    int_rst = 1'b1; cal_start = 1'b0; cal_abort = 1'b0;
    st_data = '0; st_valid = 1'b0; st_ready = 1'b0; st_sop = 1'b0; st_eop = 1'b0;
    repeat (3) @(posedge clk_clk);
    #1;
    check("rst_busy",  cal_busy,  1'b0);
    check("rst_done",  cal_done,  1'b0);
    check("rst_error", cal_error, 1'b0);
    check("rst_wr_en", bkg_wr_en, 1'b0);
    check("rst_wr_data", bkg_wr_data, 32'h0);
    int_rst = 1'b0;
    repeat (2) @(posedge clk_clk);
    #1;

    fill(0);
    run_full("const", 1'b0, 1'b0);
    check("const_word_val", got[77], 32'h0010_0020);

    fill(1);
    run_full("trunc", 1'b0, 1'b0);
    check("trunc_word5", got[5], 32'h0002_FFFF);

    fill(2);
    run_full("midstart", 1'b0, 1'b1);

    run_bad("short", 101);
    run_bad("long", FW + 1);

    fill(0);
    run_full("backpressure", 1'b1, 1'b0);
    check("bp_word_val", got[123], 32'h0010_0020);

    // Abort in the middle of frame 2: no writes, no pulses, stays idle.
    fill(2);
    w0 = wr_cnt; d0 = done_cnt; e0 = err_cnt;
    pulse_start();
    send_frame(0, FW, -1, -1, 1'b0);
    send_frame(1, FW, -1, -1, 1'b0);
    send_frame(2, FW, -1, 50, 1'b0);
    check("abort_f2_busy", abort_busy, 1'b0);
    send_frame(3, FW, -1, -1, 1'b0);
    send_frame(0, FW, -1, -1, 1'b0);
    repeat (200) @(posedge clk_clk);
    #1;
    check("abort_f2_no_writes", 32'(wr_cnt - w0),   32'd0);
    check("abort_f2_no_done",   32'(done_cnt - d0), 32'd0);
    check("abort_f2_no_error",  32'(err_cnt - e0),  32'd0);
    check("abort_f2_idle",      cal_busy,           1'b0);

    // Abort at write 50: write strobe drops on the next edge, no done pulse.
    w0 = wr_cnt; d0 = done_cnt; e0 = err_cnt;
    pulse_start();
    for (int f = 0; f < NF; f++) send_frame(f, FW, -1, -1, 1'b0);
    n = 0;
    @(negedge clk_clk);
    while (!(bkg_wr_en && bkg_wr_addr == 9'd50) && n < 400) begin @(negedge clk_clk); n++; end
    check("abort_wr_reached50", 32'(bkg_wr_en && bkg_wr_addr == 9'd50), 32'd1);
    cal_abort = 1'b1;
    @(negedge clk_clk);
    check("abort_wr_en_low", bkg_wr_en, 1'b0);
    check("abort_wr_busy",   cal_busy,  1'b0);
    cal_abort = 1'b0;
    repeat (200) @(posedge clk_clk);
    #1;
    check("abort_wr_count",   32'(wr_cnt - w0),   32'd51);
    check("abort_wr_no_done", 32'(done_cnt - d0), 32'd0);
    check("abort_wr_no_err",  32'(err_cnt - e0),  32'd0);

    fill(2);
    run_full("after_abort", 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
